// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only while busy=0
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   - rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   mthi   - write wdata into HI (ignored while busy)
//   mtlo   - write wdata into LO (ignored while busy)
//   wdata  - MTHI/MTLO data
//   busy   - operation in flight
//   done   - one-cycle pulse after HI/LO were updated by an operation
//   hi, lo - HI and LO registers
//
// Multiply takes one busy cycle. Divide is restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, followed by one cycle that applies the result signs.
// DIV_CYCLES must equal WIDTH.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  a_q, a_d;       // original rs, kept for divide-by-zero HI
    logic [WIDTH-1:0]  b_q, b_d;       // original rt, multiplier
    logic              sgn_q, sgn_d;   // signed operation
    logic [WIDTH-1:0]  dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0]  dvs_q, dvs_d;   // divisor magnitude
    logic [WIDTH-1:0]  rem_q, rem_d;   // partial remainder
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              div0_q, div0_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               take;

    // Sign-extending both operands to 2*WIDTH makes the truncated unsigned product
    // equal the signed product.
    always_comb begin
        prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    end

    always_comb begin
        trial = {rem_q, dvd_q[WIDTH-1]};
        take  = (trial >= {1'b0, dvs_q});
        // Only used when take=1, where the true difference is below dvs_q and fits WIDTH bits.
        diff  = trial[WIDTH-1:0] - dvs_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div0_d  = div0_q;

        unique case (state_q)
            StIdle: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    sgn_d = ~op[0];
                    if (!op[1]) begin
                        state_d = StMul;
                    end else begin
                        state_d = StDiv;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = (~op[0] & a[WIDTH-1]) ? -a : a;
                        dvs_d   = (~op[0] & b[WIDTH-1]) ? -b : b;
                        negq_d  = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negr_d  = ~op[0] & a[WIDTH-1];
                        div0_d  = (b == '0);
                    end
                end
            end
            StMul: begin
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StDiv: begin
                rem_d = take ? diff : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], take};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DIV_CYCLES - 1)) state_d = StFin;
            end
            StFin: begin
                if (div0_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = negq_q ? -dvd_q : dvd_q;
                    hi_d = negr_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit beside the ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU; holds results in architectural HI/LO registers read by MFHI/MFLO.
- Asserts busy so the pipeline stalls HI/LO consumers.
- Replaces the ALU's zeroed multiply-top/divide placeholders. The ALU keeps MULTU-bottom and all single-cycle ops.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- DIV_CYCLES, 32, divider iterations; must equal WIDTH.

Ports:
- clk      in   1      rising-edge clock
- rst_n    in   1      asynchronous active-low reset
- start    in   1      request; sampled only when busy=0
- op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a        in   WIDTH  multiplicand / dividend (rs)
- b        in   WIDTH  multiplier / divisor (rt)
- mthi     in   1      write wdata into HI
- mtlo     in   1      write wdata into LO
- wdata    in   WIDTH  MTHI/MTLO data
- busy     out  1      operation in flight
- done     out  1      one-cycle pulse when HI/LO updated by an op
- hi       out  WIDTH  HI register
- lo       out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration count=0.
- States: IDLE, MUL, DIV, FIN.
- IDLE: on start, latch op/a/b and go to busy=1.
  - op[1]=0 -> MUL.
  - op[1]=1 -> DIV; counter=0, load |a|,|b| (signed) or a,b (unsigned).
- MUL: one cycle. At the next edge write the 64-bit product, upper half to hi and lower half to lo, then go to IDLE, busy=0, done=1.
  - MULT: signed x signed.
  - MULTU: unsigned x unsigned.
  - Latency start-edge to HI/LO valid: 2 edges. busy is high for 1 cycle.
- DIV: restoring shift-subtract, one quotient bit per cycle, MSB first. Counter runs 0..31; after iteration 31 go to FIN.
- FIN: apply signs, write HI (remainder) and LO (quotient), go to IDLE, busy=0, done=1.
  - busy is high for 33 cycles (32 iterations + FIN).
  - done pulses in the cycle after the FIN edge.
- Signed division truncates toward zero:
  - quotient is negative iff the operand signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero (b==0, either signedness):
  - lo=FFFFFFFF, hi=a;
  - same 33-cycle latency;
  - no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap of magnitude arithmetic).
- start while busy=1: ignored; the in-flight operation is unaffected.
- mthi/mtlo:
  - busy=0: written at the edge.
  - busy=1: ignored (pipeline guarantees stall).
- Simultaneous start with mthi/mtlo in IDLE: the write lands at that edge; the later op result overwrites HI/LO.
- mthi and mtlo together: both registers take wdata.
- done never coincides with busy=1; it deasserts after one cycle.
- hi/lo hold their value at all times except at a result write or MT write. Partial results are never visible.
- Reset mid-operation: operation abandoned; all outputs return to reset values immediately.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000005 -> busy 1 cycle; done next cycle; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; MULT with the same operands -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> busy exactly 33 cycles; then lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=00000064, b=00000007 -> lo=0000000E, hi=00000002.
- DIVU a=00000064, b=0 -> lo=FFFFFFFF, hi=00000064. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- Busy/ignore checks during DIV:
  - start MULT at iteration 5 -> ignored; DIV result correct.
  - mthi asserted while busy -> hi unchanged.
  - mtlo wdata=12345678 in IDLE -> lo=12345678 next cycle, done stays 0.
- Reset mid-operation:
  - rst_n low at DIV iteration 10 -> busy=0, done=0, hi=lo=0 asynchronously.
  - After release, DIVU 7/2 -> lo=3, hi=1.
